// File: rtl/panel_proto_pkg.sv
// Indicator-frame protocol constants shared by the panel UART transmitter and receiver.
// Byte fields, frame type code and receiver state encoding live here so both ends agree.
package panel_proto_pkg;

  localparam int START_BIT = 7;
  localparam logic [2:0] FT_LED = 3'b001;
  localparam int FRAME_LEN = 5;

  // B0: {start, type[2:0], rotary[3:0]}
  localparam int TYPE_MSB = 6;
  localparam int TYPE_LSB = 4;
  localparam int ROT_MSB = 3;
  localparam int ROT_LSB = 0;
  // B1..B3 carry 7 payload bits each; B3 splits into w tail and upper lamps
  localparam int PAY_MSB = 6;
  localparam int W_TAIL_MSB = 6;
  localparam int W_TAIL_LSB = 5;
  localparam int IND_HI_MSB = 4;
  localparam int IND_HI_LSB = 0;
  // B4: {0, ind[4:0], trailer[1:0]}
  localparam int IND_LO_MSB = 6;
  localparam int IND_LO_LSB = 2;
  localparam int TRAIL_MSB = 1;
  localparam int TRAIL_LSB = 0;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } rx_state_e;

  function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/rx_strobe.sv
// Falling-edge detector on the UART busy flag; byte_stb marks the cycle a received byte is valid.
module rx_strobe (
  input  logic clk_sys,
  input  logic rst,
  input  logic rx_busy,
  output logic byte_stb
);

  logic rx_busy_d_r;

  // Delayed copy of rx_busy for edge detection
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rx_busy_d_r <= 1'b0;
    end else begin
      rx_busy_d_r <= rx_busy;
    end
  end

  assign byte_stb = rx_busy_d_r & ~rx_busy;

endmodule

// File: rtl/panel_led_rx.sv
// Panel-side receiver: reassembles 5-byte LED frames into W, lamp and rotary registers,
// flagging framing errors, bad types and inter-byte stalls with a saturating error count.
module panel_led_rx
  import panel_proto_pkg::*;
#(
  parameter int CLK_SYS_HZ = 50_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_busy,
  output logic [0:15] w,
  output logic [9:0]  indicators,
  output logic [3:0]  rotary_pos,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int TIMEOUT_CYC = CLK_SYS_HZ / 1_000_000 * TIMEOUT_US;
  localparam int GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  rx_state_e        state_r;
  logic [2:0]       idx_r;
  logic [GAP_W-1:0] gap_r;
  logic [3:0]       rot_sh_r;
  logic [0:15]      w_sh_r;
  logic [4:0]       ind_hi_sh_r;

  logic byte_stb_s;
  logic is_start_s;
  logic type_ok_s;
  logic trailer_ok_s;
  logic timeout_s;
  logic err_s;
  logic commit_s;

  rx_strobe u_rx_strobe (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .rx_busy  (rx_busy),
    .byte_stb (byte_stb_s)
  );

  assign is_start_s   = rx_byte[START_BIT];
  assign type_ok_s    = (rx_byte[TYPE_MSB:TYPE_LSB] == FT_LED);
  assign trailer_ok_s = (rx_byte[TRAIL_MSB:TRAIL_LSB] == 2'b00);
  // A byte arriving in the timeout cycle wins, so the stall is only seen without a strobe
  assign timeout_s    = (state_r == ST_COLLECT) && !byte_stb_s &&
                        (gap_r == GAP_W'(TIMEOUT_CYC - 1));

  // Classify the current cycle: at most one error pulse, even for an aborting bad start
  always_comb begin
    err_s    = 1'b0;
    commit_s = 1'b0;
    if (byte_stb_s) begin
      if (is_start_s) begin
        err_s = (state_r == ST_COLLECT) || !type_ok_s;
      end else if (state_r == ST_IDLE) begin
        err_s = 1'b1;
      end else if (idx_r == LAST_IDX) begin
        commit_s = trailer_ok_s;
        err_s    = !trailer_ok_s;
      end else begin
        err_s = 1'b0;
      end
    end else begin
      err_s = timeout_s;
    end
  end

  // Frame FSM, shadow capture, gap counter and registered outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      gap_r       <= '0;
      rot_sh_r    <= 4'd0;
      w_sh_r      <= 16'd0;
      ind_hi_sh_r <= 5'd0;
      w           <= 16'd0;
      indicators  <= 10'd0;
      rotary_pos  <= 4'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      frame_valid <= commit_s;
      frame_err   <= err_s;
      err_cnt     <= err_s ? err_cnt_inc(err_cnt) : err_cnt;

      if (byte_stb_s) begin
        gap_r <= '0;
        if (is_start_s && type_ok_s) begin
          state_r     <= ST_COLLECT;
          idx_r       <= 3'd1;
          rot_sh_r    <= rx_byte[ROT_MSB:ROT_LSB];
          w_sh_r      <= 16'd0;
          ind_hi_sh_r <= 5'd0;
        end else if (is_start_s) begin
          state_r     <= ST_IDLE;
          idx_r       <= 3'd0;
          rot_sh_r    <= 4'd0;
          w_sh_r      <= 16'd0;
          ind_hi_sh_r <= 5'd0;
        end else if (state_r == ST_IDLE) begin
          state_r <= ST_IDLE;
        end else if (idx_r == LAST_IDX) begin
          if (commit_s) begin
            w          <= w_sh_r;
            indicators <= {ind_hi_sh_r, rx_byte[IND_LO_MSB:IND_LO_LSB]};
            rotary_pos <= rot_sh_r;
          end
          state_r     <= ST_IDLE;
          idx_r       <= 3'd0;
          rot_sh_r    <= 4'd0;
          w_sh_r      <= 16'd0;
          ind_hi_sh_r <= 5'd0;
        end else begin
          case (idx_r)
            3'd1: w_sh_r[0:6]  <= rx_byte[PAY_MSB:0];
            3'd2: w_sh_r[7:13] <= rx_byte[PAY_MSB:0];
            3'd3: begin
              w_sh_r[14:15] <= rx_byte[W_TAIL_MSB:W_TAIL_LSB];
              ind_hi_sh_r   <= rx_byte[IND_HI_MSB:IND_HI_LSB];
            end
            default: w_sh_r <= w_sh_r;
          endcase
          idx_r <= idx_r + 3'd1;
        end
      end else if (timeout_s) begin
        state_r     <= ST_IDLE;
        idx_r       <= 3'd0;
        gap_r       <= '0;
        rot_sh_r    <= 4'd0;
        w_sh_r      <= 16'd0;
        ind_hi_sh_r <= 5'd0;
      end else if (state_r == ST_COLLECT) begin
        gap_r <= gap_r + GAP_W'(1);
      end else begin
        gap_r <= gap_r;
      end
    end
  end

endmodule

// File: tb/tb_panel_led_rx.sv
// Randomised scoreboard bench for panel_led_rx: a byte-list frame model predicts every
// frame_valid / frame_err pulse, its cycle and the register values it must carry.
module tb_panel_led_rx;

  localparam int T = 100;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_busy;
  logic [0:15] w;
  logic [9:0]  indicators;
  logic [3:0]  rotary_pos;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;

  panel_led_rx #(.CLK_SYS_HZ(1_000_000), .TIMEOUT_US(T)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_busy     (rx_busy),
    .w           (w),
    .indicators  (indicators),
    .rotary_pos  (rotary_pos),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] w;
    logic [9:0]  ind;
    logic [3:0]  rot;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  fb[$];
  bit          m_in_frame = 1'b0;
  int          m_last = 0;
  logic [15:0] m_w = 16'd0;
  logic [9:0]  m_ind = 10'd0;
  logic [3:0]  m_rot = 4'd0;
  int          m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_evt(input bit is_err, input int at);
    exp_t e;
    if (is_err) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    e.is_err = is_err;
    e.w = m_w;
    e.ind = m_ind;
    e.rot = m_rot;
    e.cnt = 8'(m_cnt);
    e.cyc = at;
    exp_q.push_back(e);
  endfunction

  // frame rules applied to a list of received bytes
  function automatic void model_byte(input logic [7:0] b, input int stb);
    logic [7:0] b0, b1, b2, b3, b4;
    bit err;
    err = 1'b0;
    m_last = stb;
    if (b[7]) begin
      err = m_in_frame;
      fb.delete();
      if (b[6:4] == 3'b001) begin
        m_in_frame = 1'b1;
        fb.push_back(b);
      end else begin
        m_in_frame = 1'b0;
        err = 1'b1;
      end
    end else if (!m_in_frame) begin
      err = 1'b1;
    end else begin
      fb.push_back(b);
      if (fb.size() == 5) begin
        m_in_frame = 1'b0;
        b0 = fb[0]; b1 = fb[1]; b2 = fb[2]; b3 = fb[3]; b4 = fb[4];
        fb.delete();
        if (b4[1:0] == 2'b00) begin
          m_w = {b1[6:0], b2[6:0], b3[6:5]};
          m_ind = {b3[4:0], b4[6:2]};
          m_rot = b0[3:0];
          push_evt(1'b0, stb + 1);
        end else begin
          err = 1'b1;
        end
      end
    end
    if (err) push_evt(1'b1, stb + 1);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk_sys);
    #1;
    rx_byte = b;
    rx_busy = 1'b1;
    @(posedge clk_sys);
    #1;
    rx_busy = 1'b0;
    model_byte(b, cyc);
    repeat (gap) @(posedge clk_sys);
  endtask

  task automatic idle(input int n);
    if (m_in_frame && n > T + 2) begin
      m_in_frame = 1'b0;
      fb.delete();
      push_evt(1'b1, m_last + 1 + T);
    end
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_frame(input logic [15:0] fw, input logic [9:0] fi, input logic [3:0] fr,
                            input logic [2:0] ftype, input logic [1:0] trail, input int nbytes,
                            input int gap);
    logic [7:0] by[5];
    by[0] = {1'b1, ftype, fr};
    by[1] = {1'b0, fw[15:9]};
    by[2] = {1'b0, fw[8:2]};
    by[3] = {1'b0, fw[1:0], fi[9:5]};
    by[4] = {1'b0, fi[4:0], trail};
    for (int i = 0; i < nbytes; i++) send_byte(by[i], gap);
  endtask

  task automatic do_reset();
    @(posedge clk_sys);
    #1;
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    m_in_frame = 1'b0;
    fb.delete();
    m_w = 16'd0;
    m_ind = 10'd0;
    m_rot = 4'd0;
    m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] ew, input logic [9:0] ei,
                               input logic [3:0] er, input logic [7:0] ec);
    logic [15:0] wv;
    wv = w;
    check({tag, "_w"}, 32'(wv), 32'(ew));
    check({tag, "_ind"}, 32'(indicators), 32'(ei));
    check({tag, "_rot"}, 32'(rotary_pos), 32'(er));
    check({tag, "_cnt"}, 32'(err_cnt), 32'(ec));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_sys);
      n++;
    end
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  // scoreboard monitor: every pulse must match the next predicted event
  always @(negedge clk_sys) begin
    exp_t e;
    logic [15:0] wv;
    if (!rst && (frame_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        wv = w;
        check("evt_is_err", 32'(frame_err), 32'(e.is_err));
        check("evt_valid", 32'(frame_valid), 32'(!e.is_err));
        check("evt_cycle", 32'(cyc), 32'(e.cyc));
        check("evt_w", 32'(wv), 32'(e.w));
        check("evt_ind", 32'(indicators), 32'(e.ind));
        check("evt_rot", 32'(rotary_pos), 32'(e.rot));
        check("evt_cnt", 32'(err_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk_sys);
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] sb;
    rst = 1'b1;
    rx_busy = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    check_outputs("reset", 16'h0000, 10'd0, 4'd0, 8'd0);
    check("reset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);

    // nominal frame
    send_byte(8'h95, 10); send_byte(8'h52, 10); send_byte(8'h70, 10);
    send_byte(8'h79, 10); send_byte(8'h4C, 10);
    drain();
    check_outputs("nominal", 16'hA5C3, 10'b1100110011, 4'd5, 8'd0);

    // restart mid-frame with a new full frame
    send_byte(8'h95, 3); send_byte(8'h52, 3);
    send_frame(16'h0000, 10'd0, 4'd3, 3'b001, 2'b00, 5, 3);
    drain();
    check_outputs("restart", 16'h0000, 10'd0, 4'd3, 8'd1);

    // bad type, then bad trailer
    send_byte(8'hA5, 4);
    send_byte(8'h95, 2); send_byte(8'h52, 2); send_byte(8'h70, 2);
    send_byte(8'h79, 2); send_byte(8'h4D, 2);
    drain();
    check_outputs("bad_trailer", 16'h0000, 10'd0, 4'd3, 8'd3);

    // stall inside a frame, then a clean frame
    send_byte(8'h95, 0); send_byte(8'h52, 0);
    idle(T + 20);
    send_frame(16'hA5C3, 10'b1100110011, 4'd5, 3'b001, 2'b00, 5, 1);
    drain();
    check_outputs("after_timeout", 16'hA5C3, 10'b1100110011, 4'd5, 8'd4);

    // reset after B2
    send_byte(8'h95, 1); send_byte(8'h52, 1); send_byte(8'h70, 3);
    do_reset();
    check_outputs("mid_reset", 16'h0000, 10'd0, 4'd0, 8'd0);
    send_frame(16'hA5C3, 10'b1100110011, 4'd5, 3'b001, 2'b00, 5, 2);
    drain();
    check_outputs("post_reset", 16'hA5C3, 10'b1100110011, 4'd5, 8'd0);

    // randomised frames with corruptions
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        3: send_frame(16'($urandom), 10'($urandom), 4'($urandom), 3'b001,
                      2'($urandom_range(1, 3)), 5, $urandom_range(0, 12));
        4: begin
          sb = 8'($urandom_range(0, 7));
          if (sb[2:0] == 3'b001) sb = 8'd6;
          send_frame(16'($urandom), 10'($urandom), 4'($urandom), sb[2:0], 2'b00,
                     5, $urandom_range(0, 12));
        end
        5: send_frame(16'($urandom), 10'($urandom), 4'($urandom), 3'b001, 2'b00,
                      $urandom_range(1, 4), $urandom_range(0, 12));
        6: begin
          send_frame(16'($urandom), 10'($urandom), 4'($urandom), 3'b001, 2'b00,
                     $urandom_range(0, 4), $urandom_range(0, 6));
          send_byte(8'($urandom), $urandom_range(0, 6));
        end
        default: send_frame(16'($urandom), 10'($urandom), 4'($urandom), 3'b001, 2'b00,
                            5, $urandom_range(0, 12));
      endcase
    end
    idle(T + 20);
    drain();

    // stray bytes drive the counter into saturation
    for (int i = 0; i < 300; i++) send_byte(8'h12, 0);
    drain();
    check("sat_cnt", 32'(err_cnt), 32'd255);
    check("sat_no_valid", 32'(frame_valid), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
